// File: rtl/tt_rebot_alu_sequencer.sv
// tt_rebot_alu_sequencer
//   Byte-serial command front end for the lingret ALU. Collects a three-byte
//   command (instruction, operand A, operand B) from a valid/ready byte
//   stream, holds it on the ALU ports, waits ALU_LAT cycles, then captures the
//   ALU result and offers it with zero/error flags on a valid/ready output.
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   i_in_data/i_in_valid     command byte stream in
//   o_in_ready               sequencer accepts a byte this cycle
//   i_abort                  synchronous command abort
//   o_alu_instr/o_alu_a/b    command held on the ALU inputs
//   i_alu_result             combinational ALU output
//   o_res_data/zero/err      captured result and flags
//   o_res_valid/i_res_ready  result handshake
//   o_cmd_count              completed result handshakes (wraps at 256)
module tt_rebot_alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_abort,
  output logic [DATA_W-1:0] o_alu_instr,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_zero,
  output logic              o_res_err,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [7:0]        o_cmd_count
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  typedef enum logic [2:0] {
    GET_OP = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic       ready_en_reg;   // keeps o_in_ready low until the first edge after reset
  logic [3:0] wait_cnt_reg;
  logic       in_fire, res_fire, bad_op, last_wait;

  assign o_in_ready = ready_en_reg &&
                      ((state_reg == GET_OP) || (state_reg == GET_A) || (state_reg == GET_B));
  // An abort drops whatever byte is offered in the same cycle.
  assign in_fire    = i_in_valid && o_in_ready && !i_abort;
  // A handshake still counts when it coincides with an abort.
  assign res_fire   = o_res_valid && i_res_ready;
  // Opcodes 110 and 111 are reported as errors without consulting the ALU.
  assign bad_op     = (o_alu_instr[2:1] == 2'b11);
  assign last_wait  = (state_reg == EXEC) && (wait_cnt_reg == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= GET_OP;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_abort) begin
      state_next = GET_OP;
    end else begin
      case (state_reg)
        GET_OP: if (in_fire) state_next = GET_A;
        GET_A:  if (in_fire) state_next = GET_B;
        GET_B:  if (in_fire) state_next = bad_op ? RESULT : EXEC;
        EXEC:   if (last_wait) state_next = RESULT;
        RESULT: if (res_fire) state_next = GET_OP;
        default: state_next = GET_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_reg <= 1'b0;
      wait_cnt_reg <= 4'd0;
      o_alu_instr  <= '0;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_res_data   <= '0;
      o_res_zero   <= 1'b0;
      o_res_err    <= 1'b0;
      o_res_valid  <= 1'b0;
      o_cmd_count  <= 8'd0;
    end else begin
      ready_en_reg <= 1'b1;

      if (in_fire) begin
        case (state_reg)
          GET_OP: o_alu_instr <= i_in_data;
          GET_A:  o_alu_a     <= i_in_data;
          GET_B: begin
            o_alu_b <= i_in_data;
            if (bad_op) begin
              // Unsupported opcode: report immediately, the ALU is never consulted.
              o_res_data  <= '0;
              o_res_zero  <= 1'b1;
              o_res_err   <= 1'b1;
              o_res_valid <= 1'b1;
            end else begin
              wait_cnt_reg <= LAT_LOAD;
            end
          end
          default: ;
        endcase
      end

      // The edge that takes the counter from 1 to 0 is the sample edge.
      if ((state_reg == EXEC) && !i_abort) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
        if (last_wait) begin
          o_res_data  <= i_alu_result;
          o_res_zero  <= (i_alu_result == '0);
          o_res_err   <= 1'b0;
          o_res_valid <= 1'b1;
        end
      end

      if (res_fire) begin
        o_res_valid <= 1'b0;
        o_cmd_count <= o_cmd_count + 8'd1;
      end

      if (i_abort) begin
        o_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_rebot_alu_sequencer.sv
// tb_tt_rebot_alu_sequencer
//   Directed and randomised bench for tt_rebot_alu_sequencer. Two instances
//   are built: index 0 with ALU_LAT=1 and index 1 with ALU_LAT=4. A small ALU
//   model feeds each instance; expected results are pushed to a scoreboard
//   when the last command byte is accepted and popped at the result handshake.
module tb_tt_rebot_alu_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic       abort [2];
  logic [7:0] alu_instr [2];
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [7:0] alu_result [2];
  logic [7:0] res_data [2];
  logic       res_zero [2];
  logic       res_err [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [7:0] cmd_count [2];

  logic [7:0] exp_count [2];
  exp_t       sb [$];
  exp_t       e_dir;
  int         lat;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  // Reference ALU: the opcode lives in instr[2:0]; 110/111 are unsupported.
  function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op[2:0])
      3'd0:    alu_fn = a;
      3'd1:    alu_fn = b;
      3'd2:    alu_fn = a | b;
      3'd3:    alu_fn = a & b;
      3'd4:    alu_fn = a + b;
      3'd5:    alu_fn = a ^ b;
      default: alu_fn = 8'hEE;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    tt_rebot_alu_sequencer #(
      .DATA_W (8),
      .ALU_LAT(gi == 0 ? 1 : 4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_in_data   (in_data[gi]),
      .i_in_valid  (in_valid[gi]),
      .o_in_ready  (in_ready[gi]),
      .i_abort     (abort[gi]),
      .o_alu_instr (alu_instr[gi]),
      .o_alu_a     (alu_a[gi]),
      .o_alu_b     (alu_b[gi]),
      .i_alu_result(alu_result[gi]),
      .o_res_data  (res_data[gi]),
      .o_res_zero  (res_zero[gi]),
      .o_res_err   (res_err[gi]),
      .o_res_valid (res_valid[gi]),
      .i_res_ready (res_ready[gi]),
      .o_cmd_count (cmd_count[gi])
    );
    assign alu_result[gi] = alu_fn(alu_instr[gi], alu_a[gi], alu_b[gi]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) step();
    in_data[s]  = b;
    in_valid[s] = 1'b1;
    while (!in_ready[s] && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      check("in_ready_timeout", 32'(in_ready[s]), 32'd1);
    end else begin
      step();
    end
    in_valid[s] = 1'b0;
  endtask

  task automatic send_cmd(input int s, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int gap);
    exp_t e;
    send_byte(s, op, gap);
    send_byte(s, a, gap);
    send_byte(s, b, gap);
    e.err  = (op[2:1] == 2'b11);
    e.data = e.err ? 8'h00 : alu_fn(op, a, b);
    e.zero = (e.data == 8'h00);
    sb.push_back(e);
  endtask

  // Returns the number of edges waited after the last accept edge.
  task automatic wait_valid(input int s, output int n);
    n = 0;
    while (!res_valid[s] && n < 40) begin
      step();
      n++;
    end
    check("res_valid_timeout", 32'(res_valid[s]), 32'd1);
  endtask

  task automatic recv(input int s, input int gap);
    exp_t e;
    int   n;
    wait_valid(s, n);
    if (!res_valid[s] || sb.size() == 0) return;
    repeat (gap) step();
    e = sb.pop_front();
    check("res_data", 32'(res_data[s]), 32'(e.data));
    check("res_zero", 32'(res_zero[s]), 32'(e.zero));
    check("res_err", 32'(res_err[s]), 32'(e.err));
    res_ready[s] = 1'b1;
    step();
    res_ready[s] = 1'b0;
    exp_count[s] = exp_count[s] + 8'd1;
    check("res_valid_fall", 32'(res_valid[s]), 32'd0);
    check("cmd_count", 32'(cmd_count[s]), 32'(exp_count[s]));
    $display("[TB] dut%0d result %02h z=%0b e=%0b count=%0d", s, e.data, e.zero, e.err,
             cmd_count[s]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_data[i]   = 8'h00;
      in_valid[i]  = 1'b0;
      abort[i]     = 1'b0;
      res_ready[i] = 1'b0;
      exp_count[i] = 8'd0;
    end

    // Power-on reset
    rst = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready[0]), 32'd0);
    check("rst_res_valid", 32'(res_valid[0]), 32'd0);
    check("rst_cmd_count", 32'(cmd_count[0]), 32'd0);
    step();
    rst = 1'b0;
    check("rel_in_ready_pre", 32'(in_ready[0]), 32'd0);
    step();
    check("rel_in_ready_post", 32'(in_ready[0]), 32'd1);

    // Reset while the ALU_LAT=4 instance sits in EXEC
    send_cmd(1, 8'h04, 8'h05, 8'h03, 0);
    step();
    check("exec_in_ready", 32'(in_ready[1]), 32'd0);
    check("exec_alu_instr", 32'(alu_instr[1]), 32'h04);
    rst = 1'b1;
    #1;
    check("mid_rst_alu_instr", 32'(alu_instr[1]), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a[1]), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b[1]), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready[1]), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid[1]), 32'd0);
    sb.delete();
    #1;
    rst = 1'b0;
    check("mid_rel_in_ready_pre", 32'(in_ready[1]), 32'd0);
    step();
    check("mid_rel_in_ready_post", 32'(in_ready[1]), 32'd1);

    // Add with ALU_LAT=1
    send_cmd(0, 8'h04, 8'h05, 8'h03, 0);
    wait_valid(0, lat);
    check("add_latency", 32'(lat + 1), 32'd2);
    recv(0, 0);

    // Backpressure
    send_cmd(0, 8'h04, 8'h10, 8'h20, 1);
    wait_valid(0, lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(res_valid[0]), 32'd1);
      check("bp_data", 32'(res_data[0]), 32'h30);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      step();
    end
    recv(0, 0);
    check("bp_back_in_ready", 32'(in_ready[0]), 32'd1);

    // Unsupported opcode
    send_cmd(0, 8'hF6, 8'h11, 8'h22, 0);
    wait_valid(0, lat);
    check("err_latency", 32'(lat + 1), 32'd1);
    recv(0, 0);

    // Abort after two bytes; the byte offered with the abort is dropped
    send_byte(0, 8'h04, 0);
    send_byte(0, 8'h10, 0);
    in_data[0]  = 8'h77;
    in_valid[0] = 1'b1;
    abort[0]    = 1'b1;
    step();
    in_valid[0] = 1'b0;
    abort[0]    = 1'b0;
    check("abort_alu_a_kept", 32'(alu_a[0]), 32'h10);
    check("abort_alu_instr_kept", 32'(alu_instr[0]), 32'h04);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    send_cmd(0, 8'h00, 8'h55, 8'h66, 0);
    check("abort_new_opcode", 32'(alu_instr[0]), 32'h00);
    recv(0, 0);
    send_cmd(0, 8'h03, 8'hF0, 8'h0F, 0);
    recv(0, 0);

    // Abort coinciding with a result handshake still counts
    send_cmd(0, 8'h05, 8'h0F, 8'hF0, 0);
    wait_valid(0, lat);
    e_dir = sb.pop_front();
    check("abort_hs_data", 32'(res_data[0]), 32'(e_dir.data));
    res_ready[0] = 1'b1;
    abort[0]     = 1'b1;
    step();
    res_ready[0] = 1'b0;
    abort[0]     = 1'b0;
    exp_count[0] = exp_count[0] + 8'd1;
    check("abort_hs_valid", 32'(res_valid[0]), 32'd0);
    check("abort_hs_count", 32'(cmd_count[0]), 32'(exp_count[0]));
    check("abort_hs_data_kept", 32'(res_data[0]), 32'hFF);
    $display("[TB] dut0 abort+handshake result %02h count=%0d", e_dir.data, cmd_count[0]);

    // ALU_LAT=4 latency
    send_cmd(1, 8'h04, 8'h05, 8'h03, 0);
    wait_valid(1, lat);
    check("lat4_latency", 32'(lat + 1), 32'd5);
    recv(1, 0);

    // Wrap with random stalls on both instances, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_count[0] = 8'd0;
    exp_count[1] = 8'd0;
    step();
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 256; n++) begin
        logic [7:0] op, a, b;
        op = 8'($urandom);
        a  = 8'($urandom);
        b  = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          op[2:0] = 3'd3;
          b       = 8'h00;
        end
        send_cmd(s, op, a, b, int'($urandom_range(0, 2)));
        recv(s, int'($urandom_range(0, 3)));
      end
      check("wrap_count", 32'(cmd_count[s]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
